// File: rtl/instr_seq_pkg.sv
// Purpose: shared types and constants for the instruction sequencer.
// Latency: n/a (types only).
// Backpressure: n/a.
// Contents: sequencer state enum, request kinds in priority order, flush counter width.
package instr_seq_pkg;

    localparam int FLUSH_CNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_RUN,
        ST_HALTED,
        ST_ERROR
    } state_t;

    // Request kinds seen in RUN. The decode function resolves simultaneous
    // requests: halt wins, then ret, call, jump, stall; NONE means advance.
    typedef enum logic [2:0] {
        REQ_NONE,
        REQ_HALT,
        REQ_RET,
        REQ_CALL,
        REQ_JUMP,
        REQ_STALL
    } req_t;

    function automatic req_t decode_req(input logic halt,
                                        input logic ret_en,
                                        input logic call_en,
                                        input logic jump_en,
                                        input logic stall);
        if (halt)    return REQ_HALT;
        if (ret_en)  return REQ_RET;
        if (call_en) return REQ_CALL;
        if (jump_en) return REQ_JUMP;
        if (stall)   return REQ_STALL;
        return REQ_NONE;
    endfunction

endpackage

// File: rtl/ret_addr_stack.sv
// Purpose: LIFO of return addresses for call/return.
// Latency: push/pop take effect at the next clock; top is combinational from stored state.
// Backpressure: none; push when full and pop when empty are ignored (caller checks full/empty).
// Ports: clk, rst_n (async active-low), clr (sync empty), push/pop/push_data in; top/full/empty out.
module ret_addr_stack #(
    parameter int WIDTH       = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             full,
    output logic             empty
);
    localparam int SPW = $clog2(STACK_DEPTH + 1);
    localparam int AW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [STACK_DEPTH];
    logic [SPW-1:0]   sp_q;
    logic [SPW-1:0]   sp_d;
    logic [SPW-1:0]   top_ptr;

    assign full    = (sp_q == SPW'(STACK_DEPTH));
    assign empty   = (sp_q == '0);
    assign top_ptr = sp_q - SPW'(1);
    // Entries are left in place on pop; only sp moves.
    assign top     = mem_q[top_ptr[AW-1:0]];

    always_comb begin
        sp_d = sp_q;
        if (clr)
            sp_d = '0;
        else if (push && !full)
            sp_d = sp_q + SPW'(1);
        else if (pop && !empty)
            sp_d = sp_q - SPW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sp_q <= '0;
        else
            sp_q <= sp_d;
    end

    // Storage needs no reset: nothing is readable until it has been pushed.
    always_ff @(posedge clk) begin
        if (!clr && push && !full)
            mem_q[sp_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/instr_seq_ctrl.sv
// Purpose: program-flow sequencer driving the instruction pointer counter (advance/hold/load).
// Latency: load/enable are same-cycle (Mealy); every redirect is followed by MEM_LATENCY flush cycles.
// Backpressure: stall holds the pointer in RUN; requests outside RUN (other than start) are ignored.
// Ports: start/start_addr, halt, stall, jump_en/call_en/ret_en/jump_addr, cur_ptr in;
//        ptr_enable/ptr_load_en/ptr_load_val, instr_valid, running, done, err_overflow/err_underflow out.
module instr_seq_ctrl
    import instr_seq_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int STACK_DEPTH = 4,
    parameter int MEM_LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] start_addr,
    input  logic             halt,
    input  logic             stall,
    input  logic             jump_en,
    input  logic             call_en,
    input  logic             ret_en,
    input  logic [WIDTH-1:0] jump_addr,
    input  logic [WIDTH-1:0] cur_ptr,
    output logic             ptr_enable,
    output logic             ptr_load_en,
    output logic [WIDTH-1:0] ptr_load_val,
    output logic             instr_valid,
    output logic             running,
    output logic             done,
    output logic             err_overflow,
    output logic             err_underflow
);
    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LAST = FLUSH_CNT_W'(MEM_LATENCY - 1);

    state_t                 state_q, state_d;
    logic [FLUSH_CNT_W-1:0] cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;
    logic                   unf_q, unf_d;

    req_t             req;
    logic             stk_push, stk_pop, stk_clr;
    logic             stk_full, stk_empty;
    logic [WIDTH-1:0] stk_top;
    logic             enable, load_en;
    logic [WIDTH-1:0] load_val;

    assign req = decode_req(halt, ret_en, call_en, jump_en, stall);

    ret_addr_stack #(
        .WIDTH      (WIDTH),
        .STACK_DEPTH(STACK_DEPTH)
    ) u_stack (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (stk_clr),
        .push     (stk_push),
        .pop      (stk_pop),
        .push_data(cur_ptr + WIDTH'(1)),
        .top      (stk_top),
        .full     (stk_full),
        .empty    (stk_empty)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        stk_clr  = 1'b0;
        enable   = 1'b0;
        load_en  = 1'b0;
        load_val = '0;
        case (state_q)
            ST_IDLE, ST_HALTED, ST_ERROR: begin
                if (start) begin
                    load_en  = 1'b1;
                    load_val = start_addr;
                    stk_clr  = 1'b1;
                    ovf_d    = 1'b0;
                    unf_d    = 1'b0;
                    cnt_d    = '0;
                    state_d  = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (cnt_q == FLUSH_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + FLUSH_CNT_W'(1);
                end
            end
            ST_RUN: begin
                case (req)
                    REQ_HALT: state_d = ST_HALTED;
                    REQ_RET: begin
                        if (stk_empty) begin
                            unf_d   = 1'b1;
                            state_d = ST_ERROR;
                        end else begin
                            stk_pop  = 1'b1;
                            load_en  = 1'b1;
                            load_val = stk_top;
                            cnt_d    = '0;
                            state_d  = ST_FLUSH;
                        end
                    end
                    REQ_CALL: begin
                        if (stk_full) begin
                            ovf_d   = 1'b1;
                            state_d = ST_ERROR;
                        end else begin
                            stk_push = 1'b1;
                            load_en  = 1'b1;
                            load_val = jump_addr;
                            cnt_d    = '0;
                            state_d  = ST_FLUSH;
                        end
                    end
                    REQ_JUMP: begin
                        load_en  = 1'b1;
                        load_val = jump_addr;
                        cnt_d    = '0;
                        state_d  = ST_FLUSH;
                    end
                    REQ_STALL: enable = 1'b0;
                    default:   enable = 1'b1;
                endcase
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Mealy outputs are forced low while reset is held so nothing is loaded
    // into the pointer counter even if start is already asserted.
    assign ptr_enable    = rst_n & enable;
    assign ptr_load_en   = rst_n & load_en;
    assign ptr_load_val  = rst_n ? load_val : '0;
    assign instr_valid   = (state_q == ST_RUN);
    assign running       = (state_q == ST_FLUSH) || (state_q == ST_RUN);
    assign done          = (state_q == ST_HALTED);
    assign err_overflow  = ovf_q;
    assign err_underflow = unf_q;

endmodule

// File: tb/tb_instr_seq_ctrl.sv
module tb_instr_seq_ctrl;
    localparam int W = 8;
    localparam int D = 4;
    localparam int L = 2;

    localparam int M_IDLE = 0, M_FLUSH = 1, M_RUN = 2, M_HALT = 3, M_ERR = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0, halt = 1'b0, stall = 1'b0;
    logic         jump_en = 1'b0, call_en = 1'b0, ret_en = 1'b0;
    logic [W-1:0] start_addr = '0, jump_addr = '0, cur_ptr;
    logic         ptr_enable, ptr_load_en, instr_valid, running, done;
    logic         err_overflow, err_underflow;
    logic [W-1:0] ptr_load_val;

    int total = 0;
    int bad   = 0;

    instr_seq_ctrl #(.WIDTH(W), .STACK_DEPTH(D), .MEM_LATENCY(L)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .halt(halt), .stall(stall), .jump_en(jump_en), .call_en(call_en),
        .ret_en(ret_en), .jump_addr(jump_addr), .cur_ptr(cur_ptr),
        .ptr_enable(ptr_enable), .ptr_load_en(ptr_load_en),
        .ptr_load_val(ptr_load_val), .instr_valid(instr_valid),
        .running(running), .done(done), .err_overflow(err_overflow),
        .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    // Pointer counter the sequencer drives.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)           cur_ptr <= '0;
        else if (ptr_load_en) cur_ptr <= ptr_load_val;
        else if (ptr_enable)  cur_ptr <= cur_ptr + 8'd1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: a mode, a flush countdown, a queue as the stack.
    int           m_st = M_IDLE;
    int           m_left = 0;
    logic [W-1:0] m_stk[$];
    bit           m_ovf = 0, m_unf = 0;
    logic         e_en, e_ld;
    logic [W-1:0] e_val;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_outputs", {ptr_enable, ptr_load_en, ptr_load_val, instr_valid,
                                  running, done, err_overflow, err_underflow}, 32'd0);
            m_st = M_IDLE; m_left = 0; m_stk.delete(); m_ovf = 0; m_unf = 0;
        end else begin
            chk("m_instr_valid", instr_valid, m_st == M_RUN);
            chk("m_running", running, (m_st == M_FLUSH) || (m_st == M_RUN));
            chk("m_done", done, m_st == M_HALT);
            chk("m_err_overflow", err_overflow, m_ovf);
            chk("m_err_underflow", err_underflow, m_unf);
            e_en = 0; e_ld = 0; e_val = 0;
            case (m_st)
                M_FLUSH: begin
                    m_left--;
                    if (m_left == 0) m_st = M_RUN;
                end
                M_RUN: begin
                    if (halt) m_st = M_HALT;
                    else if (ret_en) begin
                        if (m_stk.size() == 0) begin m_st = M_ERR; m_unf = 1; end
                        else begin e_ld = 1; e_val = m_stk.pop_back(); m_st = M_FLUSH; m_left = L; end
                    end else if (call_en) begin
                        if (m_stk.size() == D) begin m_st = M_ERR; m_ovf = 1; end
                        else begin
                            m_stk.push_back(cur_ptr + 8'd1);
                            e_ld = 1; e_val = jump_addr; m_st = M_FLUSH; m_left = L;
                        end
                    end else if (jump_en) begin
                        e_ld = 1; e_val = jump_addr; m_st = M_FLUSH; m_left = L;
                    end else e_en = !stall;
                end
                default: begin
                    if (start) begin
                        e_ld = 1; e_val = start_addr; m_stk.delete();
                        m_ovf = 0; m_unf = 0; m_st = M_FLUSH; m_left = L;
                    end
                end
            endcase
            chk("m_ptr_enable", ptr_enable, e_en);
            chk("m_ptr_load_en", ptr_load_en, e_ld);
            chk("m_ptr_load_val", ptr_load_val, e_val);
        end
    end

    // Advance one clock; requests are single-cycle unless re-driven.
    task automatic step();
        @(posedge clk);
        #1;
        start = 0; halt = 0; stall = 0; jump_en = 0; call_en = 0; ret_en = 0;
    endtask

    task automatic redirect();
        step(); step(); step();
    endtask

    task automatic run_to(input logic [W-1:0] addr);
        int n = 0;
        while (cur_ptr !== addr && n < 300) begin step(); n++; end
        chk("run_to", cur_ptr, addr);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        start = 1; start_addr = 8'h10;
        #1;
        chk("reset_blocks_load", ptr_load_en, 1'b0);
        chk("reset_running", running, 1'b0);
        start = 0;
        rst_n = 1;
        step();

        // 1. start
        start = 1; start_addr = 8'h10; #1;
        chk("start_load_en", ptr_load_en, 1'b1);
        chk("start_load_val", ptr_load_val, 8'h10);
        step();
        chk("flush1_valid", instr_valid, 1'b0);
        chk("flush1_en", ptr_enable, 1'b0);
        step();
        chk("flush2_valid", instr_valid, 1'b0);
        step();
        chk("run_valid", instr_valid, 1'b1);
        chk("run_en", ptr_enable, 1'b1);
        chk("run_ptr0", cur_ptr, 8'h10);
        step(); chk("run_ptr1", cur_ptr, 8'h11);
        step(); chk("run_ptr2", cur_ptr, 8'h12);

        // 2. jump and stall
        run_to(8'h14);
        jump_en = 1; jump_addr = 8'h40; #1;
        chk("jump_load_val", ptr_load_val, 8'h40);
        redirect();
        chk("jump_resume", cur_ptr, 8'h40);
        for (int i = 0; i < 3; i++) begin
            stall = 1; #1;
            chk("stall_en", ptr_enable, 1'b0);
            step();
        end
        chk("stall_ptr_held", cur_ptr, 8'h40);
        #1;
        chk("stall_release_en", ptr_enable, 1'b1);

        // 3. call / return / overflow
        jump_en = 1; jump_addr = 8'h20; redirect();
        call_en = 1; jump_addr = 8'h80; #1;
        chk("call_load_val", ptr_load_val, 8'h80);
        redirect();
        chk("call_target", cur_ptr, 8'h80);
        ret_en = 1; #1;
        chk("ret_load_val", ptr_load_val, 8'h21);
        redirect();
        for (int i = 0; i < 4; i++) begin
            call_en = 1; jump_addr = 8'h90 + 8'(i); #1;
            chk("nested_call_load", ptr_load_en, 1'b1);
            redirect();
        end
        call_en = 1; jump_addr = 8'hA0; #1;
        chk("ovf_no_load", ptr_load_en, 1'b0);
        chk("ovf_no_en", ptr_enable, 1'b0);
        step();
        chk("ovf_flag", err_overflow, 1'b1);
        chk("ovf_not_running", running, 1'b0);
        start = 1; start_addr = 8'h30; #1;
        chk("restart_load_val", ptr_load_val, 8'h30);
        step();
        chk("restart_clears_ovf", err_overflow, 1'b0);
        step(); step();

        // 4. underflow and wrap
        ret_en = 1; #1;
        chk("unf_no_load", ptr_load_en, 1'b0);
        step();
        chk("unf_flag", err_underflow, 1'b1);
        start = 1; start_addr = 8'hFE; redirect();
        step();
        chk("wrap_at_ff", cur_ptr, 8'hFF);
        call_en = 1; jump_addr = 8'h50; redirect();
        ret_en = 1; #1;
        chk("wrap_ret_val", ptr_load_val, 8'h00);
        chk("wrap_ret_ld", ptr_load_en, 1'b1);
        redirect();
        chk("wrap_resume", cur_ptr, 8'h00);

        // 5. priority: halt beats jump and stall
        halt = 1; jump_en = 1; stall = 1; jump_addr = 8'h77; #1;
        chk("prio_no_load", ptr_load_en, 1'b0);
        step();
        chk("prio_done", done, 1'b1);
        chk("prio_ptr_held", cur_ptr, 8'h00);
        step();
        chk("halted_ptr_held", cur_ptr, 8'h00);
        start = 1; start_addr = 8'h60; step();
        jump_en = 1; jump_addr = 8'h99; #1;
        chk("flush_ignores_jump", ptr_load_en, 1'b0);
        step();

        // 6. async reset in second flush cycle
        chk("pre_reset_running", running, 1'b1);
        rst_n = 0; #1;
        chk("async_rst_running", running, 1'b0);
        chk("async_rst_outs", {ptr_enable, ptr_load_en, ptr_load_val, instr_valid}, 32'd0);
        step(); step();
        rst_n = 1; #1;
        chk("post_rst_idle", {running, done, instr_valid, err_overflow, err_underflow}, 32'd0);
        start = 1; start_addr = 8'h08; redirect();
        chk("post_rst_run", cur_ptr, 8'h08);
        ret_en = 1; step();
        chk("post_rst_sp_zero", err_underflow, 1'b1);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
